// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch path.
package if_pkg;
    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries: registered storage, no bypass, flush clears pointers.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fetch_entry_t             din_i,
    output fetch_entry_t             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: sequential fetch issue, in-order response capture, redirect flush.
module if_prefetch_buffer
    import if_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc,
    output logic [31:0] if_inst,
    input  logic        if_ready
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic [31:0]   redirect_base;
    logic          issue, drop, push, pop, fifo_empty, fifo_full;
    fetch_entry_t  push_entry, head;

    assign redirect_base = {redirect_pc[31:2], 2'b00};
    assign inflight      = {1'b0, count} + {1'b0, outstanding_q};
    // Requests are only made when every granted word is guaranteed a queue slot.
    assign imem_req  = rst & ~redirect_valid & ~fifo_full & (inflight < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req & imem_gnt;
    assign drop      = (discard_q != '0);
    assign push      = imem_rvalid & ~drop & ~redirect_valid;
    assign pop       = ~fifo_empty & if_ready & ~redirect_valid;
    assign push_entry = '{pc: resp_pc_q, inst: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_entry),
        .dout_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_base;
            resp_pc_d     = redirect_base;
            outstanding_d = outstanding_q - CW'(imem_rvalid);
            // Everything still in flight after this cycle belongs to the abandoned stream.
            discard_d     = outstanding_d;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
            if (push)  resp_pc_d  = resp_pc_q + 32'(INST_BYTES);
            outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && drop) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign if_valid = ~fifo_empty;
    assign if_pc    = fifo_empty ? 32'h0 : head.pc;
    assign if_npc   = fifo_empty ? 32'h0 : head.pc + 32'(INST_BYTES);
    assign if_inst  = fifo_empty ? 32'h0 : head.inst;
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Randomized scoreboard bench for if_prefetch_buffer with an in-order memory model.
module tb_if_prefetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk, rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_npc, if_inst;

    if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_npc         (if_npc),
        .if_inst        (if_inst),
        .if_ready       (if_ready)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } mem_req_t;

    mem_req_t    pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] fetch_pc_m = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          cur_lat = 1;
    int          rv_pct = 100;
    bit          drv_timeout = 0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor + reference model: queue of expected head entries, list of granted requests.
    always @(negedge clk) begin
        mem_req_t    r;
        logic        exp_req;
        logic [63:0] h;
        if (drv_timeout) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_budget @cyc %0d: got timeout expected event", cyc);
            drv_timeout = 0;
        end
        if (rst == 1'b0) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'h0);
            exp_q.delete();
            pend_q.delete();
            fetch_pc_m = RESET_PC;
            epoch++;
        end else begin
            exp_req = !redirect_valid && (exp_q.size() + pend_q.size() < DEPTH);
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            chk("imem_addr", imem_addr, fetch_pc_m);
            chk("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                chk("if_pc", if_pc, h[63:32]);
                chk("if_npc", if_npc, h[63:32] + 32'd4);
                chk("if_inst", if_inst, h[31:0]);
            end else begin
                chk("idle_pc", if_pc, 32'h0);
                chk("idle_inst", if_inst, 32'h0);
            end
            if (imem_req && imem_gnt) begin
                pend_q.push_back('{addr: imem_addr, pc: fetch_pc_m, epoch: epoch, due: cyc + cur_lat});
                fetch_pc_m = fetch_pc_m + 32'd4;
            end
            if (exp_q.size() != 0 && if_ready && !redirect_valid) void'(exp_q.pop_front());
            if (imem_rvalid && pend_q.size() != 0) begin
                r = pend_q.pop_front();
                if (!redirect_valid && r.epoch == epoch) begin
                    chk("no_push_full", {31'b0, exp_q.size() >= DEPTH}, 32'h0);
                    exp_q.push_back({r.pc, mem_word(r.pc)});
                end
            end
            if (redirect_valid) begin
                epoch++;
                exp_q.delete();
                fetch_pc_m = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    // Driver: one call per cycle; memory answers the oldest due request.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
        repeat (3) tick();

        // Streaming from reset
        rst = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1; cur_lat = 1;
        repeat (30) tick();

        // Back-pressure then drain
        do_reset();
        if_ready = 1'b0;
        repeat (20) tick();
        if_ready = 1'b1;
        repeat (10) tick();

        // Redirect with two requests in flight
        do_reset();
        cur_lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend_q.size() >= 2) found = 1;
        end
        if (found) begin
            redirect_valid = 1'b1; redirect_pc = 32'h2002;
            tick();
        end else drv_timeout = 1;
        repeat (20) tick();

        // Redirect coincident with a response and a consuming IF stage
        cur_lat = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_rvalid) found = 1;
        end
        if (found) begin
            redirect_valid = 1'b1; redirect_pc = 32'h3000;
            tick();
        end else drv_timeout = 1;
        repeat (15) tick();

        // Grant stall after the first grant
        cur_lat = 1;
        do_reset();
        tick();
        imem_gnt = 1'b0;
        repeat (5) tick();
        imem_gnt = 1'b1;
        repeat (10) tick();

        // Address wrap, then reset mid-stream
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        repeat (8) tick();
        do_reset();
        repeat (10) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            imem_gnt = ($urandom_range(0, 99) < 70);
            if_ready = ($urandom_range(0, 99) < 60);
            cur_lat  = $urandom_range(1, 4);
            rv_pct   = 80;
            rst      = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            tick();
        end
        rst = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1; rv_pct = 100; cur_lat = 1;
        repeat (10) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
